instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/instr_fetch_queue.sv | 175 +++++++++++++++++
 tb/tb_instr_fetch_queue.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: credit-based imem requester feeding a 2-entry decode FIFO.
// Optional misaligned-fetch trap entry enabled by macro IFQ_ALIGN_CHECK_EN.
module instr_fetch_queue (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic        pc_advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_err
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned SUM_W = 3;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            err;
  } entry_t;

  entry_t [DEPTH-1:0]           slot_q, slot_d;
  logic   [DEPTH-1:0]           slot_vld_q, slot_vld_d;
  logic   [DEPTH-1:0][XLEN-1:0] aq_q, aq_d;
  logic                         aq_rd_q, aq_rd_d;
  logic   [CNT_W-1:0]           in_flight_q, in_flight_d;
  logic   [CNT_W-1:0]           discard_q, discard_d;

  logic [XLEN-1:0]  fetch_addr;
  logic [CNT_W-1:0] occupancy;
  logic [SUM_W-1:0] owed;
  logic             credit, misalign, align_stall, align_push;
  logic             req, grant, rsp_valid, rsp_drop, rsp_accept, pop;
  logic             wr_idx;
  entry_t           rsp_entry, align_entry;

  assign fetch_addr = {pc[XLEN-1:2], 2'b00};
  assign occupancy  = CNT_W'(slot_vld_q[0]) + CNT_W'(slot_vld_q[1]);
  assign owed       = SUM_W'(in_flight_q) + SUM_W'(discard_q);

  // A request is only issued when the FIFO is guaranteed room for its response.
  assign credit = ((SUM_W'(occupancy) + SUM_W'(in_flight_q)) < SUM_W'(DEPTH)) &&
                  (discard_q == '0) && !flush && reset && !align_stall;

  assign req        = credit && !misalign;
  assign align_push = credit && misalign;
  assign grant      = req && imem_gnt;

  // Responses with nothing owed (e.g. stragglers from before a reset) are ignored.
  assign rsp_valid  = imem_rvalid && (owed != '0);
  assign rsp_drop   = rsp_valid && ((discard_q != '0) || flush);
  assign rsp_accept = rsp_valid && !rsp_drop;
  assign pop        = slot_vld_q[0] && instr_ready && !flush;
  assign wr_idx     = aq_rd_q ^ in_flight_q[0];

`ifdef IFQ_ALIGN_CHECK_EN
  logic align_stall_q, align_stall_d;

  assign misalign      = (pc[1:0] != 2'b00);
  assign align_stall   = align_stall_q;
  assign align_stall_d = flush ? 1'b0 : (align_stall_q || align_push);

  always_ff @(posedge clk) begin
    if (!reset) align_stall_q <= 1'b0;
    else        align_stall_q <= align_stall_d;
  end
`else
  logic unused_pc_lo;

  assign misalign     = 1'b0;
  assign align_stall  = 1'b0;
  assign unused_pc_lo = ^pc[1:0];
`endif

  always_comb begin
    rsp_entry       = '0;
    rsp_entry.instr = imem_rdata;
    rsp_entry.pc    = aq_q[aq_rd_q];
    align_entry       = '0;
    align_entry.instr = NOP_INSTR;
    align_entry.pc    = pc;
    align_entry.err   = 1'b1;
  end

  // Counters and issued-address queue.
  always_comb begin
    in_flight_d = in_flight_q;
    discard_d   = discard_q;
    aq_d        = aq_q;
    aq_rd_d     = aq_rd_q;
    if (flush) begin
      in_flight_d = '0;
      discard_d   = CNT_W'(owed + SUM_W'(grant) - SUM_W'(rsp_valid));
      aq_rd_d     = 1'b0;
    end else begin
      in_flight_d = in_flight_q + CNT_W'(grant) - CNT_W'(rsp_accept);
      discard_d   = discard_q - CNT_W'(rsp_drop);
      if (grant) aq_d[wr_idx] = fetch_addr;
      aq_rd_d = aq_rd_q ^ rsp_accept;
    end
  end

  // FIFO as a shift pair: slot 0 is always the head; pop first, then pushes in age order.
  always_comb begin
    slot_d     = slot_q;
    slot_vld_d = slot_vld_q;
    if (flush) begin
      slot_d     = '0;
      slot_vld_d = '0;
    end else begin
      if (pop) begin
        slot_d[0]     = slot_q[1];
        slot_vld_d[0] = slot_vld_q[1];
        slot_d[1]     = '0;
        slot_vld_d[1] = 1'b0;
      end
      if (rsp_accept) begin
        if (!slot_vld_d[0]) begin
          slot_d[0]     = rsp_entry;
          slot_vld_d[0] = 1'b1;
        end else begin
          slot_d[1]     = rsp_entry;
          slot_vld_d[1] = 1'b1;
        end
      end
      if (align_push) begin
        if (!slot_vld_d[0]) begin
          slot_d[0]     = align_entry;
          slot_vld_d[0] = 1'b1;
        end else begin
          slot_d[1]     = align_entry;
          slot_vld_d[1] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_q      <= '0;
      slot_vld_q  <= '0;
      aq_q        <= '0;
      aq_rd_q     <= 1'b0;
      in_flight_q <= '0;
      discard_q   <= '0;
    end else begin
      slot_q      <= slot_d;
      slot_vld_q  <= slot_vld_d;
      aq_q        <= aq_d;
      aq_rd_q     <= aq_rd_d;
      in_flight_q <= in_flight_d;
      discard_q   <= discard_d;
    end
  end

  assign imem_req    = req;
  assign imem_addr   = fetch_addr;
  assign pc_advance  = grant || align_push;
  assign instr_valid = slot_vld_q[0];
  assign instr       = slot_q[0].instr;
  assign instr_pc    = slot_q[0].pc;
  assign instr_err   = slot_q[0].err;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue; expected head entries kept in a scoreboard queue.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset, flush, imem_gnt, imem_rvalid, instr_ready;
  logic [31:0] pc, imem_rdata;
  logic        pc_advance, imem_req, instr_valid, instr_err;
  logic [31:0] imem_addr, instr, instr_pc;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  instr_fetch_queue dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .flush       (flush),
    .pc_advance  (pc_advance),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_err   (instr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] i, input logic [31:0] p, input logic e);
    exp_t x;
    x.instr = i;
    x.pc    = p;
    x.err   = e;
    sb.push_back(x);
  endtask

  // Compare the FIFO head against the oldest expected entry; take=1 consumes it.
  task automatic expect_head(input string tag, input bit take);
    exp_t x;
    chk({tag, ".valid"}, 32'(instr_valid), 32'd1);
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s.sb: observed=empty expected=entry", tag);
    end else begin
      x = sb[0];
      chk({tag, ".instr"}, instr, x.instr);
      chk({tag, ".pc"}, instr_pc, x.pc);
      chk({tag, ".err"}, 32'(instr_err), 32'(x.err));
      if (take) void'(sb.pop_front());
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; pc = '0; flush = 1'b0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst.valid", 32'(instr_valid), 32'd0);
    chk("rst.instr", instr, 32'd0);
    chk("rst.pc", instr_pc, 32'd0);
    chk("rst.err", 32'(instr_err), 32'd0);
    chk("rst.req", 32'(imem_req), 32'd0);
    chk("rst.adv", 32'(pc_advance), 32'd0);

    // Basic fetch at 0x100
    next(); reset = 1'b1; pc = 32'h100; imem_gnt = 1'b1; #1;
    chk("basic.req", 32'(imem_req), 32'd1);
    chk("basic.addr", imem_addr, 32'h100);
    chk("basic.adv", 32'(pc_advance), 32'd1);
    next(); imem_gnt = 1'b0; pc = 32'h104; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    push_exp(32'h0050_0093, 32'h100, 1'b0); #1;
    chk("basic.lat", 32'(instr_valid), 32'd0);
    next(); imem_rvalid = 1'b0; instr_ready = 1'b1; #1;
    expect_head("basic", 1'b1);
    next(); instr_ready = 1'b0; #1;
    chk("basic.empty", 32'(instr_valid), 32'd0);
    chk("basic.zero", instr, 32'd0);

    // Back-pressure: two entries held, no request while full
    next(); pc = 32'h0; imem_gnt = 1'b1; #1;
    chk("bp.req0", 32'(imem_req), 32'd1);
    chk("bp.addr0", imem_addr, 32'h0);
    next(); pc = 32'h4; imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
    push_exp(32'h1111_1111, 32'h0, 1'b0); #1;
    chk("bp.req1", 32'(imem_req), 32'd1);
    chk("bp.addr1", imem_addr, 32'h4);
    next(); pc = 32'h8; imem_rdata = 32'h2222_2222;
    push_exp(32'h2222_2222, 32'h4, 1'b0); #1;
    chk("bp.nocredit", 32'(imem_req), 32'd0);
    chk("bp.noadv", 32'(pc_advance), 32'd0);
    next(); imem_gnt = 1'b0; imem_rvalid = 1'b0; #1;
    chk("bp.full_req", 32'(imem_req), 32'd0);
    expect_head("bp.held", 1'b0);
    next(); #1;
    expect_head("bp.stable", 1'b0);
    next(); instr_ready = 1'b1; #1;
    expect_head("bp.d0", 1'b1);
    next(); #1;
    expect_head("bp.d1", 1'b1);
    next(); instr_ready = 1'b0; #1;
    chk("bp.drained", 32'(instr_valid), 32'd0);

    // Simultaneous push and pop with one entry queued
    next(); pc = 32'h10; imem_gnt = 1'b1; #1;
    next(); pc = 32'h14; imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0001;
    push_exp(32'hAAAA_0001, 32'h10, 1'b0); #1;
    next(); pc = 32'h18; imem_gnt = 1'b0; imem_rdata = 32'hAAAA_0002; instr_ready = 1'b1;
    push_exp(32'hAAAA_0002, 32'h14, 1'b0); #1;
    expect_head("pp.e0", 1'b1);
    next(); imem_rvalid = 1'b0; instr_ready = 1'b0; #1;
    expect_head("pp.e1", 1'b0);
    next(); instr_ready = 1'b1; #1;
    expect_head("pp.e1pop", 1'b1);
    next(); instr_ready = 1'b0; #1;
    chk("pp.one_entry", 32'(instr_valid), 32'd0);

    // Flush one cycle after second grant with two in flight
    next(); pc = 32'h20; imem_gnt = 1'b1; #1;
    next(); pc = 32'h24; #1;
    chk("fl.req2", 32'(imem_req), 32'd1);
    next(); pc = 32'h200; imem_gnt = 1'b0; flush = 1'b1; #1;
    chk("fl.req_flush", 32'(imem_req), 32'd0);
    next(); flush = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0001; #1;
    chk("fl.req_disc2", 32'(imem_req), 32'd0);
    chk("fl.adv_disc2", 32'(pc_advance), 32'd0);
    next(); imem_rdata = 32'hDEAD_0002; #1;
    chk("fl.req_disc1", 32'(imem_req), 32'd0);
    chk("fl.drop1", 32'(instr_valid), 32'd0);
    next(); imem_rvalid = 1'b0; #1;
    chk("fl.drop2", 32'(instr_valid), 32'd0);
    chk("fl.req_new", 32'(imem_req), 32'd1);
    chk("fl.addr_new", imem_addr, 32'h200);
    next(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_F00D;
    push_exp(32'h0BAD_F00D, 32'h200, 1'b0); #1;
    next(); imem_rvalid = 1'b0; instr_ready = 1'b1; #1;
    expect_head("fl.new", 1'b1);
    next(); instr_ready = 1'b0; #1;
    chk("fl.empty", 32'(instr_valid), 32'd0);

    // rvalid landing in the flush cycle is dropped
    next(); pc = 32'h30; imem_gnt = 1'b1; #1;
    next(); imem_gnt = 1'b0; flush = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0003; pc = 32'h300; #1;
    next(); flush = 1'b0; imem_rvalid = 1'b0; #1;
    chk("flc.drop", 32'(instr_valid), 32'd0);
    next(); #1;
    chk("flc.still", 32'(instr_valid), 32'd0);

    // Reset mid-fetch with an entry queued and one in flight
    next(); pc = 32'h40; imem_gnt = 1'b1; #1;
    next(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h4444_0000; #1;
    next(); imem_rvalid = 1'b0; pc = 32'h44; imem_gnt = 1'b1; #1;
    chk("mr.pre_valid", 32'(instr_valid), 32'd1);
    chk("mr.pre_instr", instr, 32'h4444_0000);
    next(); imem_gnt = 1'b0; reset = 1'b0; #1;
    chk("mr.req", 32'(imem_req), 32'd0);
    chk("mr.adv", 32'(pc_advance), 32'd0);
    next(); reset = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0004; #1;
    chk("mr.valid", 32'(instr_valid), 32'd0);
    chk("mr.instr", instr, 32'd0);
    chk("mr.pc", instr_pc, 32'd0);
    chk("mr.err", 32'(instr_err), 32'd0);
    next(); imem_rvalid = 1'b0; #1;
    chk("mr.stray", 32'(instr_valid), 32'd0);
    chk("mr.stray_instr", instr, 32'd0);

`ifdef IFQ_ALIGN_CHECK_EN
    // Misaligned pc produces a trap entry and stalls until flush
    next(); pc = 32'h102; imem_gnt = 1'b1; #1;
    chk("al.req", 32'(imem_req), 32'd0);
    chk("al.adv", 32'(pc_advance), 32'd1);
    push_exp(32'h0000_0013, 32'h102, 1'b1);
    next(); pc = 32'h104; #1;
    chk("al.stall", 32'(imem_req), 32'd0);
    expect_head("al.entry", 1'b0);
    next(); instr_ready = 1'b1; #1;
    expect_head("al.pop", 1'b1);
    next(); instr_ready = 1'b0; #1;
    chk("al.stall2", 32'(imem_req), 32'd0);
    next(); flush = 1'b1; #1;
    next(); flush = 1'b0; #1;
    chk("al.resume", 32'(imem_req), 32'd1);
    next(); imem_gnt = 1'b0; #1;
`endif

    chk("sb.empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
